sgmii_rx_framer: RTL and testbench

Upstream feeder for the 9-bit S/GMII cycle async FIFO on the receive path. Takes raw GMII receive signals in the clk_in domain and undoes 10/100 byte replication. Strips preamble/SFD and emits tagged 9-bit words {ctrl, byte} with the push/full handshake. Handles FIFO overflow mid-frame by truncating the frame and closing it with an error marker, so the consumer always sees a balanced SOF/EOF sequence.

---
 rtl/sgmii_rx_framer.sv | 222 ++++++++++++++++++++++
 tb/tb_sgmii_rx_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_rx_framer.sv
// GMII receive framer: removes 10/100 byte replication, strips preamble/SFD
// and emits tagged 9-bit words {ctrl, byte} towards the receive FIFO.
// Overflow mid-frame truncates the frame and closes it with an error EOF.
module sgmii_rx_framer #(
    parameter int unsigned MAX_PREAMBLE = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  speed,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic        full,
    output logic [8:0]  fifo_in,
    output logic        push,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    localparam int unsigned PW = $clog2(MAX_PREAMBLE + 2);

    localparam logic [8:0] W_SOF      = 9'h1FB;
    localparam logic [8:0] W_EOF_GOOD = 9'h1FD;
    localparam logic [8:0] W_EOF_ERR  = 9'h1FE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP,
        S_PEND
    } state_t;

    state_t          state, state_n;
    logic [6:0]      rep_cnt;
    logic [6:0]      rep_max;
    logic            strobe;
    logic [PW-1:0]   pre_cnt, pre_cnt_n;
    logic            pend_valid, pend_valid_n;
    logic            pend_err, pend_err_n;
    logic            pend_rx, pend_rx_n;
    logic            emit;
    logic [8:0]      word;
    logic            frame_inc;
    logic            drop_inc;

    // Replication factor minus one for the selected line rate
    always_comb begin
        case (speed)
            2'b01:   rep_max = 7'd9;
            2'b00:   rep_max = 7'd99;
            default: rep_max = 7'd0;
        endcase
    end

    // Replication divider: held at zero while idle so the first valid cycle is sampled
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rep_cnt <= '0;
        end else if (!rx_dv || rep_cnt >= rep_max) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 7'd1;
        end
    end

    assign strobe = !rx_dv || (rep_cnt == '0);

    // Next-state, word request and counter-increment decode
    always_comb begin
        state_n      = state;
        pre_cnt_n    = pre_cnt;
        pend_valid_n = pend_valid;
        pend_err_n   = pend_err;
        pend_rx_n    = pend_rx;
        emit         = 1'b0;
        word         = '0;
        frame_inc    = 1'b0;
        drop_inc     = 1'b0;

        case (state)
            S_IDLE: begin
                if (strobe && rx_dv) begin
                    if (rxd == 8'h55) begin
                        state_n   = S_PREAMBLE;
                        pre_cnt_n = PW'(1);
                    end else if (rxd == 8'hD5 && !full) begin
                        emit    = 1'b1;
                        word    = W_SOF;
                        state_n = S_DATA;
                    end else begin
                        drop_inc = 1'b1;
                        state_n  = S_DROP;
                    end
                end
            end

            S_PREAMBLE: begin
                if (strobe) begin
                    if (!rx_dv) begin
                        state_n = S_IDLE;
                    end else if (rxd == 8'h55) begin
                        if (32'(pre_cnt) >= MAX_PREAMBLE) begin
                            drop_inc = 1'b1;
                            state_n  = S_DROP;
                        end else begin
                            pre_cnt_n = pre_cnt + PW'(1);
                        end
                    end else if (rxd == 8'hD5 && !full) begin
                        emit    = 1'b1;
                        word    = W_SOF;
                        state_n = S_DATA;
                    end else begin
                        drop_inc = 1'b1;
                        state_n  = S_DROP;
                    end
                end
            end

            S_DATA: begin
                if (strobe) begin
                    if (!rx_dv) begin
                        frame_inc = 1'b1;
                        if (!full) begin
                            emit    = 1'b1;
                            word    = W_EOF_GOOD;
                            state_n = S_IDLE;
                        end else begin
                            pend_valid_n = 1'b1;
                            pend_err_n   = 1'b0;
                            state_n      = S_PEND;
                        end
                    end else if (rx_er) begin
                        drop_inc = 1'b1;
                        state_n  = S_DROP;
                        if (!full) begin
                            emit = 1'b1;
                            word = W_EOF_ERR;
                        end else begin
                            pend_valid_n = 1'b1;
                            pend_err_n   = 1'b1;
                        end
                    end else if (!full) begin
                        emit = 1'b1;
                        word = {1'b0, rxd};
                    end else begin
                        // Blocked data byte: frame is truncated, EOF error queued for later
                        pend_valid_n = 1'b1;
                        pend_err_n   = 1'b1;
                        drop_inc     = 1'b1;
                        state_n      = S_DROP;
                    end
                end
            end

            S_DROP: begin
                if (strobe && !rx_dv) begin
                    state_n = pend_valid ? S_PEND : S_IDLE;
                end
            end

            S_PEND: begin
                // Remember a frame that begins while the EOF is still waiting for space
                pend_rx_n = pend_rx | rx_dv;
                if (!full) begin
                    emit         = 1'b1;
                    word         = pend_err ? W_EOF_ERR : W_EOF_GOOD;
                    pend_valid_n = 1'b0;
                    pend_rx_n    = 1'b0;
                    if (rx_dv || pend_rx) begin
                        drop_inc = 1'b1;
                    end
                    state_n = rx_dv ? S_DROP : S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    // State, pending-EOF and preamble counter registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            pre_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            pend_rx    <= 1'b0;
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            pend_valid <= pend_valid_n;
            pend_err   <= pend_err_n;
            pend_rx    <= pend_rx_n;
        end
    end

    // Registered FIFO write port; fifo_in holds its value between pushes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            push    <= 1'b0;
            fifo_in <= '0;
        end else begin
            push <= emit;
            if (emit) begin
                fifo_in <= word;
            end
        end
    end

    // Frame statistics counters, wrapping
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            frame_cnt <= frame_cnt + 16'(frame_inc);
            drop_cnt  <= drop_cnt + 16'(drop_inc);
        end
    end

endmodule

// File: tb/tb_sgmii_rx_framer.sv
// Scoreboard bench for sgmii_rx_framer: stimulus queues expected FIFO words,
// a negedge monitor pops and compares on every push.
module tb_sgmii_rx_framer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [1:0]  speed;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic        full;
    logic [8:0]  fifo_in;
    logic        push;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    int         cyc_n = 0;
    bit         chk_spacing = 1'b0;
    bit         have_last = 1'b0;
    int         last_push = 0;

    sgmii_rx_framer #(.MAX_PREAMBLE(15)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .speed     (speed),
        .rxd       (rxd),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .full      (full),
        .fifo_in   (fifo_in),
        .push      (push),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_n++;

    // Monitor: every push must match the head of the expected queue
    always @(negedge clk_in) begin
        if (rst_in === 1'b0 && push === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_push: got %03h, required no push", fifo_in);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (fifo_in !== e) begin
                    n_fail++;
                    $display("FAIL fifo_word: got %03h, required %03h", fifo_in, e);
                end
            end
            if (chk_spacing) begin
                if (have_last) begin
                    n_checks++;
                    if (cyc_n - last_push != 10) begin
                        n_fail++;
                        $display("FAIL push_spacing: got %0d, required 10", cyc_n - last_push);
                    end
                end
                last_push = cyc_n;
                have_last = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rx_dv  = 1'b0;
        rx_er  = 1'b0;
        rxd    = 8'h00;
        full   = 1'b0;
        repeat (3) cyc();
        rst_in = 1'b0;
        cyc();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic er, input logic f, input int hold);
        rxd   = b;
        rx_dv = 1'b1;
        rx_er = er;
        full  = f;
        repeat (hold) cyc();
    endtask

    task automatic end_frame();
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 8'h00;
        full  = 1'b0;
        cyc();
    endtask

    task automatic send_frame(input int npre, input int nbytes, input int hold, input int er_at,
                              input int full_lo, input int full_hi, input bit check_sof);
        for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0, 1'b0, hold);
        send_byte(8'hD5, 1'b0, 1'b0, hold);
        if (check_sof) check("sof_latency", {22'd0, push, fifo_in}, {22'd0, 1'b1, 9'h1FB});
        for (int i = 1; i <= nbytes; i++)
            send_byte(8'(i), 1'(i == er_at), 1'(i >= full_lo && i <= full_hi), hold);
        end_frame();
    endtask

    task automatic exp_frame(input int nbytes, input logic [8:0] eof);
        exp_q.push_back(9'h1FB);
        for (int i = 1; i <= nbytes; i++) exp_q.push_back({1'b0, 8'(i)});
        exp_q.push_back(eof);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc();
        repeat (3) cyc();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        speed = 2'b10;
        do_reset();
        check("rst_push", push, 0);
        check("rst_fifo_in", fifo_in, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // 1000 mode good frame
        exp_frame(64, 9'h1FD);
        send_frame(7, 64, 1, 0, 0, 0, 1'b1);
        drain("drain_1000");
        check("frame_cnt_1000", frame_cnt, 1);
        check("drop_cnt_1000", drop_cnt, 0);

        // 100 mode: same words, 10 cycles apart
        do_reset();
        speed = 2'b01;
        have_last = 1'b0;
        chk_spacing = 1'b1;
        exp_frame(64, 9'h1FD);
        send_frame(7, 64, 10, 0, 0, 0, 1'b0);
        drain("drain_100");
        chk_spacing = 1'b0;
        check("frame_cnt_100", frame_cnt, 1);

        // rx_er on byte 10
        do_reset();
        speed = 2'b10;
        exp_frame(9, 9'h1FE);
        send_frame(7, 64, 1, 10, 0, 0, 1'b0);
        drain("drain_rxer");
        check("drop_cnt_rxer", drop_cnt, 1);
        check("frame_cnt_rxer", frame_cnt, 0);

        // FIFO full over bytes 20..25
        do_reset();
        exp_frame(19, 9'h1FE);
        send_frame(7, 64, 1, 0, 20, 25, 1'b0);
        drain("drain_full");
        check("drop_cnt_full", drop_cnt, 1);
        check("frame_cnt_full", frame_cnt, 0);

        // Over-long preamble dropped, then a good short frame
        do_reset();
        send_frame(20, 4, 1, 0, 0, 0, 1'b0);
        drain("drain_longpre");
        check("drop_cnt_longpre", drop_cnt, 1);
        exp_frame(2, 9'h1FD);
        send_frame(7, 2, 1, 0, 0, 0, 1'b0);
        drain("drain_after_pre");
        check("frame_cnt_after_pre", frame_cnt, 1);
        check("drop_cnt_after_pre", drop_cnt, 1);

        // 10 mode: reset asserted mid-DATA, counters above are non-zero here
        speed = 2'b00;
        exp_q.push_back(9'h1FB);
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 8'(i)});
        for (int i = 0; i < 2; i++) send_byte(8'h55, 1'b0, 1'b0, 100);
        send_byte(8'hD5, 1'b0, 1'b0, 100);
        for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b0, 1'b0, 100);
        send_byte(8'h04, 1'b0, 1'b0, 50);
        check("pre_rst_queue", exp_q.size(), 0);
        #2;
        rst_in = 1'b1;
        #1;
        check("midrst_push", push, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        rx_dv = 1'b0;
        rxd   = 8'h00;
        repeat (3) cyc();
        rst_in = 1'b0;
        repeat (5) cyc();
        exp_frame(2, 9'h1FD);
        send_frame(7, 2, 100, 0, 0, 0, 1'b0);
        drain("drain_after_rst");
        check("frame_cnt_after_rst", frame_cnt, 1);
        check("drop_cnt_after_rst", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
